// File: rtl/uart_rx_if.sv
// Bus between the UART receive sequencer and its host/right-justify side.
// The master side drives the serial line, the frame config, the host read
// strobe and the justified word. The slave side is the receive controller.
interface uart_rx_if;
  logic        RX;
  logic [18:0] K;
  logic        EIGHT;
  logic        PEN;
  logic        OHEL;
  logic        READ;
  logic [9:0]  Q;
  logic        EIGHT_L;
  logic        PEN_L;
  logic [9:0]  Q_J;
  logic [7:0]  DATA;
  logic        RXRDY;
  logic        PERR;
  logic        FERR;
  logic        OVF;

  modport master (
    output RX, K, EIGHT, PEN, OHEL, READ, Q_J,
    input  Q, EIGHT_L, PEN_L, DATA, RXRDY, PERR, FERR, OVF
  );

  modport slave (
    input  RX, K, EIGHT, PEN, OHEL, READ, Q_J,
    output Q, EIGHT_L, PEN_L, DATA, RXRDY, PERR, FERR, OVF
  );
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: synchronises RX, validates the start bit at half a
// bit time, samples the remaining bits mid-bit into a 10-bit shift register,
// then checks parity/framing on the right-justified word and raises RXRDY.
module uart_rx_controller (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic        rx_m, rx_s;
  logic        armed;
  logic [18:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic        eight_l, pen_l, ohel_l;
  logic [9:0]  q;
  logic [7:0]  data;
  logic        rxrdy, perr, ferr, ovf;

  logic [3:0]  n_bits;
  logic [18:0] half_k;
  logic        start_hit, half_tc, bit_tc, last_bit;
  logic [7:0]  word;

  // Parity error: enabled frames whose received parity bit disagrees with
  // the XOR of the data bits folded with the odd/even select.
  function automatic logic parity_err(input logic [7:0] d, input logic par,
                                      input logic odd, input logic en);
    return en & (par != ((^d) ^ odd));
  endfunction

  // Stop bit position in the justified word depends on data width and parity.
  function automatic logic stop_of(input logic [9:0] qj, input logic e,
                                   input logic p);
    if (e & p)      return qj[9];
    else if (e ^ p) return qj[8];
    else            return qj[7];
  endfunction

  assign n_bits    = 4'd8 + {3'b000, eight_l} + {3'b000, pen_l};
  assign half_k    = bus.K >> 1;
  // Compare with >= so a K reduced mid-bit still wraps instead of overrunning.
  assign half_tc   = baud_cnt >= (half_k - 19'd1);
  assign bit_tc    = baud_cnt >= (bus.K - 19'd1);
  assign last_bit  = (bit_cnt + 4'd1) == n_bits;
  assign start_hit = armed & ~rx_s;
  assign word      = eight_l ? bus.Q_J[7:0] : {1'b0, bus.Q_J[6:0]};

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.RX;
      rx_s <= rx_m;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_hit) state_nxt = START;
      START:   if (half_tc) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_tc && last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Baud and bit counters; both held at zero outside START/DATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        START: baud_cnt <= half_tc ? 19'd0 : baud_cnt + 19'd1;
        DATA: begin
          if (bit_tc) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
          end else begin
            baud_cnt <= baud_cnt + 19'd1;
          end
        end
        default: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Mid-bit samples enter at the MSB so right-justify can align by shifting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   q <= 10'h3FF;
    else if (state == DATA && bit_tc) q <= {rx_s, q[9:1]};
  end

  // Arm on an idle-high line; latch frame config on the start edge.
  // Disarming after each frame keeps a held-low break from retriggering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed   <= 1'b0;
      eight_l <= 1'b0;
      pen_l   <= 1'b0;
      ohel_l  <= 1'b0;
    end else if (state == IDLE) begin
      if (rx_s) armed <= 1'b1;
      if (start_hit) begin
        eight_l <= bus.EIGHT;
        pen_l   <= bus.PEN;
        ohel_l  <= bus.OHEL;
      end
    end else if (state == DONE) begin
      armed <= 1'b0;
    end
  end

  // Host-facing byte and flags; a frame completion wins over a coincident READ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data  <= 8'h00;
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == DONE) begin
      data  <= word;
      rxrdy <= 1'b1;
      perr  <= parity_err(word, eight_l ? bus.Q_J[8] : bus.Q_J[7], ohel_l, pen_l);
      ferr  <= ~stop_of(bus.Q_J, eight_l, pen_l);
      ovf   <= ~bus.READ & (rxrdy | ovf);
    end else if (bus.READ) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

  assign bus.Q       = q;
  assign bus.EIGHT_L = eight_l;
  assign bus.PEN_L   = pen_l;
  assign bus.DATA    = data;
  assign bus.RXRDY   = rxrdy;
  assign bus.PERR    = perr;
  assign bus.FERR    = ferr;
  assign bus.OVF     = ovf;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: table of frames with hand-derived results,
// random frames against a frame-level model, and sequences for false start,
// break, overrun, set-wins and reset mid-frame. Right-justify is modelled here.
module tb_uart_rx_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  uart_rx_if bus ();

  uart_rx_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Right-justify: after N = 8+EIGHT_L+PEN_L shifts the first bit sits at Q[10-N].
  logic [1:0] sh;
  assign sh      = 2'd2 - {1'b0, bus.EIGHT_L} - {1'b0, bus.PEN_L};
  assign bus.Q_J = bus.Q >> sh;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic       e, p, o, par, stp;
    logic [7:0] xd;
    logic       xperr, xferr;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic build(input logic [7:0] d, input logic e, input logic p,
                       input logic par, input logic stp,
                       output logic [11:0] fb, output int nb);
    int idx;
    fb = '1;
    fb[0] = 1'b0;
    idx = 1;
    for (int i = 0; i < (e ? 8 : 7); i++) begin
      fb[idx] = d[i];
      idx++;
    end
    if (p) begin
      fb[idx] = par;
      idx++;
    end
    fb[idx] = stp;
    nb = idx + 1;
  endtask

  // Drives one frame at negedges (cycle j), then idle_cyc cycles of idle_val.
  // rise = first j whose following negedge shows RXRDY high; read_at = posedge
  // index at which READ is sampled high (-1 for none).
  task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o,
                      input logic par, input logic stp, input int k,
                      input logic idle_val, input int idle_cyc, input int read_at,
                      output int rise);
    logic [11:0] fb;
    int nb, tot;
    build(d, e, p, par, stp, fb, nb);
    bus.EIGHT = e;
    bus.PEN   = p;
    bus.OHEL  = o;
    bus.K     = k[18:0];
    tot  = nb * k + idle_cyc;
    rise = -1;
    for (int j = 0; j < tot; j++) begin
      @(negedge clk);
      if (j > 0 && bus.RXRDY === 1'b1 && rise < 0) rise = j;
      bus.READ = (read_at > 0 && j == read_at - 1);
      bus.RX   = (j / k < nb) ? fb[j / k] : idle_val;
    end
    @(negedge clk);
    bus.READ = 1'b0;
  endtask

  task automatic read_pulse();
    @(negedge clk);
    bus.READ = 1'b1;
    @(negedge clk);
    bus.READ = 1'b0;
  endtask

  function automatic int exp_rise(input int k, input logic e, input logic p);
    return (k / 2) + (8 + int'(e) + int'(p)) * k + 4;
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    logic [7:0] d, md;
    logic e, p, o, par, stp, xp;
    int k;
    logic [11:0] fb;
    int nb;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[2] = '{8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'hD5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    tbl[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1};

    bus.RX = 1'b1; bus.K = 19'd16; bus.EIGHT = 1'b1; bus.PEN = 1'b0;
    bus.OHEL = 1'b0; bus.READ = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_q", bus.Q, 10'h3FF);
    chk("rst_data", bus.DATA, 8'h00);
    chk("rst_flags", {bus.RXRDY, bus.PERR, bus.FERR, bus.OVF}, 4'b0000);
    chk("rst_cfg", {bus.EIGHT_L, bus.PEN_L}, 2'b00);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Table frames, each read back afterwards
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].d, tbl[i].e, tbl[i].p, tbl[i].o, tbl[i].par, tbl[i].stp,
           16, 1'b1, 32, -1, rise);
      chk($sformatf("tbl%0d_rise", i), rise, exp_rise(16, tbl[i].e, tbl[i].p));
      chk($sformatf("tbl%0d_data", i), bus.DATA, tbl[i].xd);
      chk($sformatf("tbl%0d_perr", i), bus.PERR, tbl[i].xperr);
      chk($sformatf("tbl%0d_ferr", i), bus.FERR, tbl[i].xferr);
      chk($sformatf("tbl%0d_ovf", i), bus.OVF, 1'b0);
      read_pulse();
      chk($sformatf("tbl%0d_read", i), {bus.RXRDY, bus.PERR, bus.FERR, bus.OVF}, 4'b0000);
    end

    // Random frames against the frame-level model
    for (int i = 0; i < 20; i++) begin
      d   = 8'($urandom);
      e   = 1'($urandom_range(0, 1));
      p   = 1'($urandom_range(0, 1));
      o   = 1'($urandom_range(0, 1));
      par = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 3) != 0);
      k   = int'($urandom_range(4, 24));
      md  = e ? d : {1'b0, d[6:0]};
      xp  = p & (par != ((^md) ^ o));
      send(d, e, p, o, par, stp, k, 1'b1, 2 * k, -1, rise);
      chk($sformatf("rnd%0d_rise", i), rise, exp_rise(k, e, p));
      chk($sformatf("rnd%0d_data", i), bus.DATA, md);
      chk($sformatf("rnd%0d_flags", i), {bus.PERR, bus.FERR}, {xp, ~stp});
      read_pulse();
      chk($sformatf("rnd%0d_read", i), bus.RXRDY, 1'b0);
    end

    // False start: K/4-cycle low pulse, then a good frame
    bus.K = 19'd16;
    @(negedge clk); bus.RX = 1'b0;
    repeat (4) @(negedge clk);
    bus.RX = 1'b1;
    repeat (48) @(negedge clk);
    chk("false_start_rdy", bus.RXRDY, 1'b0);
    send(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 32, -1, rise);
    chk("after_false_rise", rise, exp_rise(16, 1'b1, 1'b0));
    chk("after_false_data", bus.DATA, 8'h5A);
    read_pulse();

    // Break: 8O1 with stop 0, line held low, no retrigger until high
    send(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16, 1'b0, 48, -1, rise);
    chk("brk_rise", rise, exp_rise(16, 1'b1, 1'b1));
    chk("brk_ferr", {bus.FERR, bus.PERR}, 2'b10);
    chk("brk_data", bus.DATA, 8'h3C);
    read_pulse();
    repeat (16) @(negedge clk);
    chk("brk_no_retrigger", bus.RXRDY, 1'b0);
    bus.RX = 1'b1;
    repeat (32) @(negedge clk);
    send(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16, 1'b1, 32, -1, rise);
    chk("brk2_rise", rise, exp_rise(16, 1'b1, 1'b1));
    chk("brk2_data", bus.DATA, 8'h00);
    chk("brk2_flags", {bus.PERR, bus.FERR}, 2'b00);
    read_pulse();

    // Overrun: two frames without READ
    send(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 32, -1, rise);
    send(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 32, -1, rise);
    chk("ovr_ovf", {bus.RXRDY, bus.OVF}, 2'b11);
    chk("ovr_data", bus.DATA, 8'h22);
    read_pulse();
    chk("ovr_clear", {bus.RXRDY, bus.OVF}, 2'b00);

    // Set wins: READ sampled in the DONE cycle of a second frame
    send(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 32, -1, rise);
    chk("sw_first", {bus.RXRDY, bus.OVF}, 2'b10);
    send(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 32,
         exp_rise(16, 1'b1, 1'b0), rise);
    chk("sw_rdy_ovf", {bus.RXRDY, bus.OVF}, 2'b10);
    chk("sw_data", bus.DATA, 8'h44);

    // Reset during bit 4 of an 8E1 frame, RXRDY still set from before
    build(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, fb, nb);
    bus.EIGHT = 1'b1; bus.PEN = 1'b1; bus.OHEL = 1'b0; bus.K = 19'd16;
    for (int j = 0; j < 4 * 16 + 8; j++) begin
      @(negedge clk);
      bus.RX = fb[j / 16];
    end
    chk("pre_rst_cfg", {bus.EIGHT_L, bus.PEN_L}, 2'b11);
    reset_n = 1'b0;
    bus.RX  = 1'b1;
    @(negedge clk);
    chk("mid_rst_q", bus.Q, 10'h3FF);
    chk("mid_rst_data", bus.DATA, 8'h00);
    chk("mid_rst_flags", {bus.RXRDY, bus.PERR, bus.FERR, bus.OVF}, 4'b0000);
    chk("mid_rst_cfg", {bus.EIGHT_L, bus.PEN_L}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1, 32, -1, rise);
    chk("post_rst_rise", rise, exp_rise(16, 1'b1, 1'b1));
    chk("post_rst_data", bus.DATA, 8'hC3);
    chk("post_rst_flags", {bus.PERR, bus.FERR, bus.OVF}, 3'b000);
    read_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Receive-side sequencer for the full UART. It oversamples the serial line, detects and validates the start bit, and shifts data, parity and stop bits into a 10-bit shift register. It hands that register to the existing right-justify block, then checks parity and framing on the justified word and presents the byte to the host through a ready/read handshake.

## Interface
Parameters:
- none. Frame format and baud divisor are run-time inputs.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `RX`  in  1  serial line, asynchronous, idle high
- `K`  in  19  clock cycles per bit; must be ≥ 4
- `EIGHT`  in  1  1 = 8 data bits, 0 = 7 data bits
- `PEN`  in  1  parity enable
- `OHEL`  in  1  parity select: 1 = odd, 0 = even
- `READ`  in  1  one-cycle host read strobe; clears `RXRDY` and all flags
- `Q`  out  10  raw shift register, to right-justify input
- `EIGHT_L`, `PEN_L`  out  1 each  frame config latched at start, to right-justify
- `Q_J`  in  10  justified word returned by right-justify (combinational)
- `DATA`  out  8  received byte; bit 7 forced to 0 in 7-bit mode
- `RXRDY`  out  1  byte available
- `PERR`, `FERR`, `OVF`  out  1 each  parity, framing and overrun error flags

## Operation
- **Input synchronisation:** `RX` passes through a 2-flop synchroniser, giving `rx_s`. Both flops reset to 1.
- **Frame config:** `EIGHT`, `PEN` and `OHEL` are latched on start detection. They are held in `EIGHT_L`, `PEN_L` and `OHEL_L` until the next start.
- **Bits after the start bit:** `N = 8 + EIGHT_L + PEN_L`, i.e. 8, 9 or 10.
- **Shift rule:** each sample shifts in at the MSB: `Q <= {rx_s, Q[9:1]}`. After N shifts, right-justify aligns the frame so that:
  - `PEN_L=1`: parity bit is `Q_J[8]` when `EIGHT_L=1`, `Q_J[7]` when `EIGHT_L=0`.
  - Stop bit: `Q_J[9]` if `EIGHT_L & PEN_L`; `Q_J[8]` if exactly one of `EIGHT_L`, `PEN_L` is set; `Q_J[7]` if neither is set.
- **Checks:**
  - Data is `Q_J[7:0]` (8-bit mode) or `{1'b0, Q_J[6:0]}` (7-bit mode).
  - Expected parity = XOR of data bits XOR `OHEL_L`.
  - PERR condition: `PEN_L` and received parity ≠ expected parity.
  - FERR condition: stop bit = 0.
- **FSM states:**
  - IDLE: baud and bit counters held at 0. If armed and `rx_s=0`, latch config and go to START.
  - START: baud counter runs 0..(K>>1)−1. At terminal count, `rx_s=1` means a false start: go to IDLE. Otherwise go to DATA with the baud counter cleared.
  - DATA: baud counter runs 0..K−1. At terminal count, shift `rx_s` in and increment the bit counter. When the bit counter reaches N, go to DONE.
  - DONE (1 cycle): load `DATA`, `PERR`, `FERR`; set `RXRDY`; set `OVF` if `RXRDY` was already 1 and `READ` is not asserted this cycle. Return to IDLE with armed cleared.
- **Armed flag:** set when IDLE sees `rx_s=1`. A break (RX held low after FERR) therefore does not retrigger until the line returns high.
- **Flag handshake:**
  - `READ` clears `RXRDY`, `PERR`, `FERR` and `OVF`.
  - If `READ` coincides with DONE, set wins: `RXRDY=1`, the new flags load, and `OVF=0`.
  - Flags stay sticky until `READ`. `DATA` is overwritten on every DONE, including on overrun.
- **Change during a frame:** `K` changes mid-frame take effect at the next counter wrap. Config changes mid-frame are ignored.

## Timing
- **Reset values:** state IDLE, armed 0, `Q=10'h3FF`, `DATA=8'h00`, `RXRDY=PERR=FERR=OVF=0`, `EIGHT_L=PEN_L=0`. All outputs are registered.
- **Reset mid-frame:** the frame is abandoned immediately and every register returns to its reset value.
- **Sample points:**
  - Start validation at (K>>1) cycles after `rx_s` falls.
  - Each following bit sampled K cycles later, nominally mid-bit.
- **Latency:** `RXRDY` rises 1 cycle after the stop-bit sample, i.e. `(K>>1) + N·K + 2` cycles after `rx_s` falls. Add 2 cycles of synchroniser delay from `RX`.
- **Read response:** `READ` sampled high clears `RXRDY` on the next edge.

## Test plan
- **8N1 good frame:** K=16, `EIGHT=1`, `PEN=0`, send 0xA5 → `DATA=8'hA5`, `RXRDY=1` at the computed cycle, `PERR=FERR=OVF=0`; `READ` → `RXRDY=0`.
- **7E1 and 7O1:** send 0x41 with parity 0 under even → no error, `DATA=8'h41`. Repeat with `OHEL=1` → `PERR=1`, `DATA` still `8'h41`.
- **8O1 framing:** send 0x3C with a stop bit of 0 → `FERR=1`. Hold RX low for 3 bit times → no new frame. Release high, then send 0x00 → second frame received.
- **False start:** pulse RX low for K/4 cycles → FSM returns to IDLE, `RXRDY` stays 0.
- **Overrun and set-wins:**
  - Two frames without `READ` → `OVF=1`, `DATA` equals the second byte.
  - `READ` asserted in the DONE cycle → `RXRDY=1`, `OVF=0`.
- **Reset mid-DATA:** assert `reset_n=0` during bit 4 → all outputs at reset values. A following frame is received correctly.
